// File: rtl/bsg_thermometer_ramp.sv
// Slew-limited thermometer generator: walks a registered thermometer code one unit per cycle toward an accepted target.
// Optional macro BSG_THERMOMETER_RAMP_JUMP_EN adds jump_i, which loads the target level in a single cycle.
module bsg_thermometer_ramp #(
  parameter int width_p    = 16,
  parameter int lg_width_p = $clog2(width_p+1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [lg_width_p-1:0] count_i,
  input  logic                  v_i,
`ifdef BSG_THERMOMETER_RAMP_JUMP_EN
  input  logic                  jump_i,
`endif
  output logic                  ready_o,
  output logic [width_p-1:0]    thermo_o,
  output logic [lg_width_p-1:0] count_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] ramp_s = 2'd1;
  localparam logic [1:0] done_s = 2'd2;

  localparam logic [lg_width_p-1:0] max_lvl = lg_width_p'(width_p);
  localparam logic [lg_width_p-1:0] one_lvl = lg_width_p'(1);

  logic [1:0]            state_r, state_n;
  logic [lg_width_p-1:0] level_r, level_n;
  logic [lg_width_p-1:0] target_r, target_n;
  logic [width_p-1:0]    thermo_r;
  logic [lg_width_p-1:0] req_tgt;
  logic                  accept;
  logic                  jump;

`ifdef BSG_THERMOMETER_RAMP_JUMP_EN
  assign jump = jump_i;
`else
  assign jump = 1'b0;
`endif

  function automatic logic [lg_width_p-1:0] step_toward(
    input logic [lg_width_p-1:0] cur,
    input logic [lg_width_p-1:0] tgt
  );
    if (cur < tgt)      return cur + one_lvl;
    else if (cur > tgt) return cur - one_lvl;
    else                return cur;
  endfunction

  function automatic logic [width_p-1:0] thermo_of(input logic [lg_width_p-1:0] lvl);
    logic [width_p-1:0] m;
    m = '0;
    for (int i = 0; i < width_p; i++) m[i] = (i < int'(lvl));
    return m;
  endfunction

  assign req_tgt = (count_i > max_lvl) ? max_lvl : count_i;
  assign ready_o = (state_r == idle_s);
  assign accept  = v_i & ready_o;

  // The accept edge already takes the first step, so a one-unit move lands directly in DONE.
  always_comb begin
    state_n  = state_r;
    level_n  = level_r;
    target_n = target_r;
    case (state_r)
      idle_s: begin
        if (accept) begin
          target_n = req_tgt;
          if (jump || (req_tgt == level_r)) begin
            level_n = req_tgt;
            state_n = done_s;
          end else begin
            level_n = step_toward(level_r, req_tgt);
            state_n = (level_n == req_tgt) ? done_s : ramp_s;
          end
        end
      end
      ramp_s: begin
        level_n = step_toward(level_r, target_r);
        if (level_n == target_r) state_n = done_s;
      end
      done_s:  state_n = idle_s;
      default: state_n = idle_s;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= idle_s;
      level_r  <= '0;
      target_r <= '0;
      thermo_r <= '0;
    end else begin
      state_r  <= state_n;
      level_r  <= level_n;
      target_r <= target_n;
      thermo_r <= thermo_of(level_n);
    end
  end

  assign thermo_o = thermo_r;
  assign count_o  = level_r;
  assign busy_o   = (state_r == ramp_s);
  assign done_o   = (state_r == done_s);

endmodule

// File: tb/tb_bsg_thermometer_ramp.sv
// Self-checking bench for bsg_thermometer_ramp: vector table, corner sequences, randomized run against a level model.
module tb_bsg_thermometer_ramp;

  localparam int W  = 16;
  localparam int LW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          reset_i;
  logic [LW-1:0] count_i;
  logic          v_i;
  logic          jump;
  logic          ready_o;
  logic [W-1:0]  thermo_o;
  logic [LW-1:0] count_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_thermometer_ramp #(.width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .count_i (count_i),
    .v_i     (v_i),
`ifdef BSG_THERMOMETER_RAMP_JUMP_EN
    .jump_i  (jump),
`endif
    .ready_o (ready_o),
    .thermo_o(thermo_o),
    .count_o (count_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  typedef struct {
    int         cnt;
    logic       v;
    logic [15:0] e_thermo;
    int         e_count;
    logic       e_ready;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int c, input logic v, input logic j);
    count_i = LW'(c);
    v_i     = v;
    jump    = j;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int e_thermo, input int e_count,
                         input logic e_ready, input logic e_busy, input logic e_done);
    chk({tag, "_thermo"}, int'(thermo_o), e_thermo);
    chk({tag, "_count"},  int'(count_o),  e_count);
    chk({tag, "_ready"},  int'(ready_o),  int'(e_ready));
    chk({tag, "_busy"},   int'(busy_o),   int'(e_busy));
    chk({tag, "_done"},   int'(done_o),   int'(e_done));
  endtask

  function automatic int thermo_of(input int lvl);
    return ((1 << lvl) - 1) & 16'hFFFF;
  endfunction

  // Behavioural model: level, pending target, and whether a ramp or done-cycle is in flight.
  int  m_lvl, m_tgt;
  bit  m_busy, m_done;

  task automatic model_edge(input int c, input logic v, input logic j);
    int t;
    if (m_done) m_done = 0;
    else if (m_busy) begin
      m_lvl += (m_tgt > m_lvl) ? 1 : -1;
      if (m_lvl == m_tgt) begin m_busy = 0; m_done = 1; end
    end else if (v) begin
      t = (c > W) ? W : c;
      if (j || t == m_lvl) begin m_lvl = t; m_done = 1; end
      else begin
        m_tgt = t;
        m_lvl += (t > m_lvl) ? 1 : -1;
        if (m_lvl == t) m_done = 1; else m_busy = 1;
      end
    end
  endtask

  initial begin
    logic [W-1:0] prev;
    int c;
    logic v, j;

    vecs[0]  = '{5, 1'b1, 16'h0001, 1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{0, 1'b0, 16'h0003, 2, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{0, 1'b0, 16'h0007, 3, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{0, 1'b0, 16'h000F, 4, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{0, 1'b0, 16'h001F, 5, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{0, 1'b0, 16'h001F, 5, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2, 1'b1, 16'h000F, 4, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{0, 1'b0, 16'h0007, 3, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{0, 1'b0, 16'h0003, 2, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{0, 1'b0, 16'h0003, 2, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{2, 1'b1, 16'h0003, 2, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{9, 1'b1, 16'h0003, 2, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{0, 1'b1, 16'h0001, 1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0};

    reset_i = 1'b1; count_i = '0; v_i = 1'b0; jump = 1'b0;
    #22 reset_i = 1'b0;
    #1;
    chk_all("reset", 0, 0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].cnt, vecs[i].v, 1'b0);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_thermo), vecs[i].e_count,
              vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_done);
    end

    // Saturating request from level 0.
    cyc(31, 1'b1, 1'b0);
    repeat (15) cyc(0, 1'b0, 1'b0);
    chk_all("sat_end", 16'hFFFF, 16, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0);
    chk("sat_idle_ready", int'(ready_o), 1);

    // Request equal to current level.
    cyc(16, 1'b1, 1'b0);
    chk_all("eq_done", 16'hFFFF, 16, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0);
    chk_all("eq_ready", 16'hFFFF, 16, 1'b1, 1'b0, 1'b0);

    // Requests held during a ramp are ignored.
    cyc(10, 1'b1, 1'b0);
    repeat (5) cyc($urandom_range(0, 31), 1'b1, 1'b0);
    chk_all("hold_end", 16'h03FF, 10, 1'b0, 1'b0, 1'b1);
    cyc(3, 1'b1, 1'b0);
    chk_all("hold_noacc", 16'h03FF, 10, 1'b1, 1'b0, 1'b0);
    cyc(3, 1'b1, 1'b0);
    chk_all("hold_acc", 16'h01FF, 9, 1'b0, 1'b1, 1'b0);
    repeat (8) cyc(0, 1'b0, 1'b0);
    chk_all("hold_drain", 16'h0007, 3, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-ramp at level 7.
    cyc(12, 1'b1, 1'b0);
    repeat (3) cyc(0, 1'b0, 1'b0);
    chk("areset_pre_count", int'(count_o), 7);
    #2 reset_i = 1'b1;
    #1;
    chk_all("areset", 0, 0, 1'b1, 1'b0, 1'b0);
    #1 reset_i = 1'b0;
    cyc(0, 1'b0, 1'b0);
    chk_all("areset_after", 0, 0, 1'b1, 1'b0, 1'b0);

`ifdef BSG_THERMOMETER_RAMP_JUMP_EN
    cyc(12, 1'b1, 1'b1);
    chk_all("jump", 16'h0FFF, 12, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0);
    chk_all("jump_ready", 16'h0FFF, 12, 1'b1, 1'b0, 1'b0);
    cyc(3, 1'b1, 1'b0);
    repeat (10) cyc(0, 1'b0, 1'b0);
    m_lvl = 3;
`else
    m_lvl = 0;
`endif
    m_tgt = 0; m_busy = 0; m_done = 0;

    // Randomized run against the level model.
    prev = thermo_o;
    for (int k = 0; k < 400; k++) begin
      c = $urandom_range(0, 31);
      v = ($urandom_range(0, 3) == 0);
`ifdef BSG_THERMOMETER_RAMP_JUMP_EN
      j = ($urandom_range(0, 4) == 0);
`else
      j = 1'b0;
`endif
      model_edge(c, v, j);
      cyc(c, v, j);
      chk_all($sformatf("rnd%0d", k), thermo_of(m_lvl), m_lvl,
              !m_busy && !m_done, m_busy, m_done);
      chk($sformatf("rnd%0d_popcnt", k), int'(count_o), $countones(thermo_o));
      if (!j) chk($sformatf("rnd%0d_onebit", k), int'($countones(thermo_o ^ prev) <= 1), 1);
      prev = thermo_o;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
